// File: rtl/yif_queue.sv
// Instruction-fetch unit: owns the PC, fetches one word per cycle from a
// combinational instruction memory and buffers up to DEPTH {pc, ins} entries for decode.
module yif_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            INT,
  input  logic [XLEN-1:0] entryPoint,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ins,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcp4,
  output logic [CW-1:0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN  = ~XLEN'(3);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_buf_pc  [DEPTH];
  logic [31:0]     r_buf_ins [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic w_pop;
  logic w_push;
  logic w_valid;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & out_ready;
  // A full queue may still fetch when the head leaves in the same cycle.
  assign w_push  = !INT & !redirect & ((r_count < FULL) | w_pop);

  always_ff @(posedge clk) begin
    if (INT) begin
      r_pc     <= entryPoint & ALIGN;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      // Flush discards any same-cycle pop: the presented head is not consumed.
      r_pc     <= redirect_pc & ALIGN;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]  <= r_pc;
      r_buf_ins[r_wr_ptr] <= imem_data;
    end
  end

  assign imem_addr = r_pc;
  assign count     = r_count;
  assign out_valid = w_valid;
  assign out_ins   = w_valid ? r_buf_ins[r_rd_ptr] : 32'h0;
  assign out_pc    = w_valid ? r_buf_pc[r_rd_ptr] : '0;
  assign out_pcp4  = w_valid ? (r_buf_pc[r_rd_ptr] + XLEN'(4)) : '0;

endmodule

// File: tb/tb_yif_queue.sv
// Bench for yif_queue: three instances (DEPTH 4, 2, 8) share INT/redirect stimulus
// and are checked each cycle against an arithmetic model of PC and occupancy.
module tb_yif_queue;

  logic        clk = 1'b0;
  logic        INT = 1'b1;
  logic [31:0] entryPoint = 32'd128;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        rdy4 = 1'b0, rdy2 = 1'b0, rdy8 = 1'b0;

  logic [31:0] a4, a2, a8, d4, d2, d8, i4, i2, i8, p4, p2, p8, q4, q2, q8;
  logic        v4, v2, v8;
  logic [2:0]  c4;
  logic [1:0]  c2;
  logic [3:0]  c8;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc [3];
  int          m_cnt[3];
  int          dep  [3] = '{4, 2, 8};

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign d4 = mem_f(a4);
  assign d2 = mem_f(a2);
  assign d8 = mem_f(a8);

  yif_queue #(.XLEN(32), .DEPTH(4)) u_d4 (
    .clk(clk), .INT(INT), .entryPoint(entryPoint), .imem_addr(a4), .imem_data(d4),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(v4), .out_ready(rdy4),
    .out_ins(i4), .out_pc(p4), .out_pcp4(q4), .count(c4));
  yif_queue #(.XLEN(32), .DEPTH(2)) u_d2 (
    .clk(clk), .INT(INT), .entryPoint(entryPoint), .imem_addr(a2), .imem_data(d2),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(v2), .out_ready(rdy2),
    .out_ins(i2), .out_pc(p2), .out_pcp4(q2), .count(c2));
  yif_queue #(.XLEN(32), .DEPTH(8)) u_d8 (
    .clk(clk), .INT(INT), .entryPoint(entryPoint), .imem_addr(a8), .imem_data(d8),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(v8), .out_ready(rdy8),
    .out_ins(i8), .out_pc(p8), .out_pcp4(q8), .count(c8));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The queue always holds consecutive words ending just below the PC,
  // so the head is PC - 4*count.
  task automatic chk_one(int k, logic [31:0] addr, logic [31:0] cnt, logic vld,
                         logic [31:0] ins, logic [31:0] pc, logic [31:0] pcp4);
    logic [31:0] head;
    head = m_pc[k] - 32'(4 * m_cnt[k]);
    chk($sformatf("d%0d_addr", dep[k]), addr, m_pc[k]);
    chk($sformatf("d%0d_count", dep[k]), cnt, 32'(m_cnt[k]));
    chk($sformatf("d%0d_valid", dep[k]), {31'b0, vld}, {31'b0, m_cnt[k] != 0});
    chk($sformatf("d%0d_pc", dep[k]), pc, (m_cnt[k] != 0) ? head : 32'h0);
    chk($sformatf("d%0d_pcp4", dep[k]), pcp4, (m_cnt[k] != 0) ? head + 32'd4 : 32'h0);
    chk($sformatf("d%0d_ins", dep[k]), ins, (m_cnt[k] != 0) ? mem_f(head) : 32'h0);
  endtask

  task automatic step(logic i_int, logic i_red, logic [31:0] rpc, logic [2:0] rdy);
    logic r;
    logic pop, push;
    INT = i_int;
    redirect = i_red;
    redirect_pc = rpc;
    rdy4 = rdy[0];
    rdy2 = rdy[1];
    rdy8 = rdy[2];
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      r = rdy[k];
      if (i_int) begin
        m_pc[k] = {entryPoint[31:2], 2'b00};
        m_cnt[k] = 0;
      end else if (i_red) begin
        m_pc[k] = {rpc[31:2], 2'b00};
        m_cnt[k] = 0;
      end else begin
        pop  = (m_cnt[k] > 0) && r;
        push = (m_cnt[k] < dep[k]) || pop;
        if (push) m_pc[k] = m_pc[k] + 32'd4;
        m_cnt[k] = m_cnt[k] + int'(push) - int'(pop);
      end
    end
    #1;
    chk_one(0, a4, {29'b0, c4}, v4, i4, p4, q4);
    chk_one(1, a2, {30'b0, c2}, v2, i2, p2, q2);
    chk_one(2, a8, {28'b0, c8}, v8, i8, p8, q8);
  endtask

  initial begin
    // Reset at entry point 128.
    entryPoint = 32'd128;
    step(1'b1, 1'b0, 32'h0, 3'b111);
    chk("rst_addr", a4, 32'd128);
    chk("rst_count", {29'b0, c4}, 32'd0);
    chk("rst_valid", {31'b0, v4}, 32'd0);
    chk("rst_ins", i4, 32'd0);

    // Back-pressure: fill DEPTH=4, PC holds at 144.
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 32'h0, 3'b000);
    chk("bp_count", {29'b0, c4}, 32'd4);
    chk("bp_addr", a4, 32'd144);
    chk("bp_head", p4, 32'd128);

    // Drain in order; full push+pop keeps count at 4 while PC advances.
    for (int n = 0; n < 5; n++) begin
      chk("bp_order", p4, 32'(128 + 4 * n));
      step(1'b0, 1'b0, 32'h0, 3'b111);
      chk("full_count", {29'b0, c4}, 32'd4);
      chk("full_addr", a4, 32'(148 + 4 * n));
    end

    // Redirect with 3 entries queued and out_ready high.
    step(1'b1, 1'b0, 32'h0, 3'b000);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 32'h0, 3'b000);
    chk("pre_redir_count", {29'b0, c4}, 32'd3);
    step(1'b0, 1'b1, 32'h203, 3'b111);
    chk("redir_count", {29'b0, c4}, 32'd0);
    chk("redir_addr", a4, 32'h200);
    step(1'b0, 1'b0, 32'h0, 3'b000);
    chk("redir_head", p4, 32'h200);

    // PC wrap across 2^32.
    entryPoint = 32'hFFFF_FFF8;
    step(1'b1, 1'b0, 32'h0, 3'b111);
    step(1'b0, 1'b0, 32'h0, 3'b111);
    chk("wrap_pc0", p4, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 3'b111);
    chk("wrap_pc1", p4, 32'hFFFF_FFFC);
    chk("wrap_pcp4", q4, 32'h0);
    step(1'b0, 1'b0, 32'h0, 3'b111);
    chk("wrap_pc2", p4, 32'h0);

    // INT beats a simultaneous redirect mid-stream.
    entryPoint = 32'h0000_1000;
    step(1'b0, 1'b0, 32'h0, 3'b000);
    step(1'b0, 1'b0, 32'h0, 3'b000);
    step(1'b1, 1'b1, 32'h0000_4000, 3'b111);
    chk("int_addr", a4, 32'h0000_1000);
    chk("int_count", {29'b0, c4}, 32'd0);

    // Randomised run against the model.
    for (int n = 0; n < 2000; n++) begin
      logic ri, rr;
      logic [31:0] rp;
      ri = ($urandom_range(0, 199) == 0);
      rr = ($urandom_range(0, 31) == 0);
      rp = $urandom;
      if (ri) entryPoint = $urandom;
      step(ri, rr, rp, 3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
